// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions used by the EX-stage divider.
// Holds the divider state encoding and the default operand width / counter width.
package cpu_defs_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude if it fits.
// The partial remainder is always below the divisor, so a successful
// subtraction fits in WIDTH bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Trial subtraction; keep the difference when non-negative, otherwise restore.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// One quotient bit per cycle, result {remainder, quotient} written to hilo_o
// with a one-cycle done pulse that drives the HI/LO write enable.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations
// and completes in the cycle after accept with the divide-by-zero result.
module div_unit
    import cpu_defs_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] hilo_o
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    div_state_e state_q, state_d;

    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] raw_a_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last_iter;
    logic             fast_zero;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_sh[WIDTH-1]),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Operand magnitudes (unsigned, so the most negative value is exact) and accept decode.
    always_comb begin
        sign_a    = is_signed & dividend[WIDTH-1];
        sign_b    = is_signed & divisor[WIDTH-1];
        abs_a     = sign_a ? -dividend : dividend;
        abs_b     = sign_b ? -divisor : divisor;
        accept    = ((state_q == DIV_IDLE) || (state_q == DIV_DONE)) && start && !annul;
        last_iter = (state_q == DIV_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
`ifdef DIV_ZERO_FAST_EN
        fast_zero = (divisor == '0);
`else
        fast_zero = 1'b0;
`endif
    end

    // Sign fixup of the final iteration; divide-by-zero yields a fixed pattern.
    always_comb begin
        fin_q = {quo_sh[WIDTH-2:0], step_bit};
        fin_r = step_rem;
        res_q = dz_q ? '1 : (q_neg_q ? -fin_q : fin_q);
        res_r = dz_q ? raw_a_q : (r_neg_q ? -fin_r : fin_r);
    end

    // Next-state and status outputs; annul overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                if (accept) begin
                    state_d = fast_zero ? DIV_DONE : DIV_RUN;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (last_iter) begin
                    state_d = DIV_DONE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (annul) begin
            state_d = DIV_IDLE;
        end
        busy = (state_q == DIV_RUN);
        done = (state_q == DIV_DONE) && !annul;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_sh  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            raw_a_q <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            hilo_o  <= '0;
        end else if (accept) begin
            quo_sh  <= abs_a;
            rem_q   <= '0;
            dvsr_q  <= abs_b;
            raw_a_q <= dividend;
            q_neg_q <= sign_a ^ sign_b;
            r_neg_q <= sign_a;
            dz_q    <= (divisor == '0);
            cnt_q   <= '0;
            if (fast_zero) begin
                hilo_o <= {dividend, {WIDTH{1'b1}}};
            end
        end else if ((state_q == DIV_RUN) && !annul) begin
            quo_sh <= {quo_sh[WIDTH-2:0], step_bit};
            rem_q  <= step_rem;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                hilo_o <= {res_r, res_q};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        busy;
    logic        done;
    logic [63:0] hilo_o;

    int checks = 0;
    int passes = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .annul     (annul),
        .busy      (busy),
        .done      (done),
        .hilo_o    (hilo_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time guard so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int expLatency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    // Drive one operation from the current negedge; returns at the negedge where done is seen.
    // glitchCycle > 0 pulses a bogus start request during that DIV cycle.
    task automatic applyStimulus(input string tag, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, input int glitchCycle);
        int lat;
        logic [63:0] expRes;
        expRes    = refDiv(sgn, a, b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        checkOutput({tag, "_busy1"}, {63'd0, busy}, {63'd0, (expLatency(b) != 1)});
        while (!done && lat < 60) begin
            if (lat == glitchCycle) begin
                start     = 1'b1;
                is_signed = ~sgn;
                dividend  = ~a;
                divisor   = b + 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLatency(b)));
        checkOutput({tag, "_result"}, hilo_o, expRes);
        checkOutput({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          doneSeen;

        resetn    = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        annul     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_hilo", hilo_o, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        checkOutput("divu_100_7_exact", hilo_o, {32'h2, 32'hE});
        @(negedge clk);
        checkOutput("done_is_pulse", {63'd0, done}, 64'd0);

        applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("div_m7_2_exact", hilo_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        checkOutput("div_7_m2_exact", hilo_o, {32'h1, 32'hFFFF_FFFD});
        applyStimulus("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("div_ovf_exact", hilo_o, {32'h0, 32'h8000_0000});
        applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        checkOutput("divu_max_1_exact", hilo_o, {32'h0, 32'hFFFF_FFFF});
        applyStimulus("div_5_0", 1'b1, 32'd5, 32'd0, 0);
        checkOutput("div_5_0_exact", hilo_o, {32'h5, 32'hFFFF_FFFF});
        applyStimulus("divu_neg_0", 1'b0, 32'hFFFF_FFF0, 32'd0, 0);
        applyStimulus("div_neg_0", 1'b1, 32'hFFFF_FFF0, 32'd0, 0);

        // Mid-DIV start request must be ignored.
        @(negedge clk);
        applyStimulus("glitch_start", 1'b0, 32'd1000, 32'd33, 5);

        // Annul at cycle 10: no done pulse, result held, fresh start at cycle 11.
        @(negedge clk);
        held      = hilo_o;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        checkOutput("annul_done_c10", {63'd0, done}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        checkOutput("annul_done_c11", {63'd0, done}, 64'd0);
        checkOutput("annul_busy_c11", {63'd0, busy}, 64'd0);
        checkOutput("annul_hilo_held", hilo_o, held);
        applyStimulus("after_annul", 1'b1, 32'hFFFF_F000, 32'd7, 0);

        // Back-to-back: second start issued in the DONE cycle.
        applyStimulus("b2b_second", 1'b0, 32'd999, 32'd10, 0);

        // Async reset mid-operation.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd500;
        divisor   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_mid_hilo", hilo_o, 64'd0);
        doneSeen = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("rst_mid_no_done", 64'(doneSeen), 64'd0);

        // Randomized operations, occasionally idle between them.
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = -32'($urandom_range(1, 15));
                2: rb = 32'd0;
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            applyStimulus($sformatf("rand%0d", i), rs, ra, rb, 0);
        end

        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
